grid_readout_rx: RTL and testbench
==================================

// Module: grid_readout_rx
// PURPOSE
// - Receiving end of the serial solution-readout interface of the grid: requests a readout, accepts
//   one cell value per handshake in row-major order, and re-emits it as (row, col, number).
// - Independently checks every received cell against row/column/block occupancy, so a bench or host
//   gets a pass/fail verdict on the generated sudoku without trusting the generator.
// - Sits between the grid's solution output and the host/testbench side.
// PARAMETERS
// - ORD   3          block order; LEN = ORD*ORD symbols, AREA = LEN*LEN cells (derived localparams)
// - IDXW  $clog2(ORD**4)  cell index width (derived, not overridden)
// PORTS
// - clock      in   1          clock, rising edge
// - reset      in   1          synchronous, active-high
// - rq_start   in   1          host requests a readout+check
// - rq_read    out  1          one-cycle pulse to the grid: begin serial transmission
// - in_valid   in   1          grid presents a cell value
// - in_ready   out  1          this block accepts a cell value
// - in_value   in   LEN        one-hot cell value (bit k = number k); 0 = empty tile
// - cell_valid out  1          registered pulse: one decoded cell
// - cell_row   out  $clog2(LEN)  row of decoded cell
// - cell_col   out  $clog2(LEN)  column of decoded cell
// - cell_num   out  $clog2(LEN)  binary number of decoded cell (index of the set bit; 0 if invalid)
// - done       out  1          level: full grid received, verdict valid
// - pass       out  1          level, qualified by done: no violation in the whole grid
// - err_idx    out  IDXW       row-major index of the first offending cell (valid when done & ~pass)
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; row/col/blk occupancy masks, cell index, error flag cleared.
//   Reset mid-readout abandons the transfer; no done, no verdict.
// - FSM (one-hot): IDLE, REQUEST, RECV, DONE.
//   IDLE:    in_ready=0. rq_start -> REQUEST; clear masks, index=0, err flag=0.
//   REQUEST: rq_read=1 for exactly this cycle -> RECV.
//   RECV:    in_ready=1. Handshake = in_valid & in_ready. rq_start ignored.
//            Handshake on index AREA-1 -> DONE; otherwise index++.
//   DONE:    done=1, pass=~err. Holds until rq_start -> REQUEST (clears masks, index, err, done).
// - Per handshake at index i: r=i/LEN, c=i%LEN, b=(r/ORD)*ORD + c/ORD.
//   Violation if in_value not exactly one-hot (zero or >1 bit), or
//   in_value & (rowmask[r] | colmask[c] | blkmask[b]) != 0.
//   Masks OR-in in_value regardless of violation. First violation latches err_idx=i; later ones
//   do not overwrite. Stream is always drained to AREA cells even after an error.
// - cell_valid/cell_row/cell_col/cell_num registered: asserted the cycle after each handshake;
//   row/col/num hold last value while cell_valid=0.
// - done rises the cycle after the AREA-th handshake (same edge as last cell_valid).
// - in_valid with in_ready=0 has no effect; grid must hold in_value until accepted. Gaps in
//   in_valid are legal at any point and add no state.
// - Index and row/col counters never wrap inside RECV: AREA-1 is terminal.
// TESTING (run at ORD=2: LEN=4, AREA=16, and ORD=3 for one smoke run)
// - ORD=2, rq_start, stream valid grid 1234/3412/2143/4321 (one-hot) back-to-back -> rq_read pulses
//   once, 16 cell_valid, cell 5 reports row1 col1 num3, done=1 pass=1 one cycle after 16th handshake.
// - Same grid but cell 1 = value 1 (duplicate in row 0) -> done=1, pass=0, err_idx=1.
// - Cell 6 sent as 4'b0000, cell 9 as 4'b0110 -> pass=0, err_idx=6 (first error kept).
// - Valid grid with in_valid low on alternate cycles and a 10-cycle stall mid-stream -> identical
//   cell_valid sequence and verdict; no cell accepted while in_valid=0.
// - reset after 7 handshakes, then rq_start + full valid grid -> outputs 0 during reset, no stale
//   mask bits, pass=1; then rq_start in DONE + valid grid again -> second pass=1.
// - rq_start held high throughout RECV -> no extra rq_read pulse, exactly 16 cells accepted.

Source files
------------

// File: rtl/grid_readout_rx_if.sv
// Serial cell-value link between the grid's solution output and the readout receiver.
// The grid side (master) presents one-hot cell values; the receiver (slave) requests and accepts them.
interface grid_readout_rx_if #(
  parameter int ORD = 3
);
  localparam int LEN = ORD * ORD;

  logic           rq_read;
  logic           in_valid;
  logic           in_ready;
  logic [LEN-1:0] in_value;

  modport master (
    output in_valid,
    output in_value,
    input  rq_read,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_value,
    output rq_read,
    output in_ready
  );
endinterface

// File: rtl/grid_readout_rx.sv
// Requests a serial readout of the grid, re-emits each cell as (row, col, number) and
// independently checks row/column/block occupancy to give a pass/fail verdict.
module grid_readout_rx #(
  parameter int ORD = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rq_start,
  grid_readout_rx_if.slave              grid,
  output logic                          cell_valid,
  output logic [$clog2(ORD*ORD)-1:0]    cell_row,
  output logic [$clog2(ORD*ORD)-1:0]    cell_col,
  output logic [$clog2(ORD*ORD)-1:0]    cell_num,
  output logic                          done,
  output logic                          pass,
  output logic [$clog2(ORD**4)-1:0]     err_idx
);
  localparam int LEN  = ORD * ORD;
  localparam int AREA = LEN * LEN;
  localparam int IDXW = $clog2(AREA);
  localparam int CW   = $clog2(LEN);
  localparam logic [CW-1:0] ORD_C = CW'(ORD);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_REQUEST = 4'b0010,
    S_RECV    = 4'b0100,
    S_DONE    = 4'b1000
  } state_t;

  state_t state, state_next;

  logic            clear;
  logic            accept;
  logic            last;
  logic            err;
  logic            onehot;
  logic            violation;
  logic [IDXW-1:0] idx;
  logic [CW-1:0]   row;
  logic [CW-1:0]   col;
  logic [CW-1:0]   blk;
  logic [CW-1:0]   num;
  logic [LEN-1:0]  row_mask [LEN];
  logic [LEN-1:0]  col_mask [LEN];
  logic [LEN-1:0]  blk_mask [LEN];

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    grid.rq_read  = 1'b0;
    grid.in_ready = 1'b0;
    clear         = 1'b0;
    accept        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rq_start) begin
          clear      = 1'b1;
          state_next = S_REQUEST;
        end
      end
      S_REQUEST: begin
        grid.rq_read = 1'b1;
        state_next   = S_RECV;
      end
      S_RECV: begin
        grid.in_ready = 1'b1;
        accept        = grid.in_valid;
        if (accept && last) state_next = S_DONE;
      end
      S_DONE: begin
        if (rq_start) begin
          clear      = 1'b1;
          state_next = S_REQUEST;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign last = (idx == IDXW'(AREA - 1));
  assign blk  = (row / ORD_C) * ORD_C + col / ORD_C;

  // An empty or multi-bit value is itself a violation and decodes to number 0.
  always_comb begin
    num    = '0;
    onehot = (grid.in_value != '0) && ((grid.in_value & (grid.in_value - LEN'(1))) == '0);
    for (int k = 0; k < LEN; k++) begin
      if (grid.in_value[k]) num = CW'(k);
    end
    if (!onehot) num = '0;
    violation = !onehot ||
                ((grid.in_value & (row_mask[row] | col_mask[col] | blk_mask[blk])) != '0);
  end

  // Masks absorb every accepted value, even faulty ones, so later conflicts are still seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      cell_valid <= 1'b0;
      cell_row   <= '0;
      cell_col   <= '0;
      cell_num   <= '0;
      err        <= 1'b0;
      err_idx    <= '0;
      idx        <= '0;
      row        <= '0;
      col        <= '0;
      for (int i = 0; i < LEN; i++) begin
        row_mask[i] <= '0;
        col_mask[i] <= '0;
        blk_mask[i] <= '0;
      end
    end else begin
      cell_valid <= 1'b0;
      if (clear) begin
        err     <= 1'b0;
        err_idx <= '0;
        idx     <= '0;
        row     <= '0;
        col     <= '0;
        for (int i = 0; i < LEN; i++) begin
          row_mask[i] <= '0;
          col_mask[i] <= '0;
          blk_mask[i] <= '0;
        end
      end
      if (accept) begin
        cell_valid    <= 1'b1;
        cell_row      <= row;
        cell_col      <= col;
        cell_num      <= num;
        row_mask[row] <= row_mask[row] | grid.in_value;
        col_mask[col] <= col_mask[col] | grid.in_value;
        blk_mask[blk] <= blk_mask[blk] | grid.in_value;
        if (violation && !err) begin
          err     <= 1'b1;
          err_idx <= idx;
        end
        if (!last) begin
          idx <= idx + IDXW'(1);
          if (col == CW'(LEN - 1)) begin
            col <= '0;
            row <= row + CW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
      end
    end
  end

  assign done = (state == S_DONE);
  assign pass = done & ~err;

endmodule

// File: tb/tb_grid_readout_rx.sv
// Randomized self-checking bench for grid_readout_rx: ORD=2 main runs against a sudoku-rule
// reference model, plus one ORD=3 smoke run.
module tb_grid_readout_rx;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic rq_start;
  logic rq_start3;

  grid_readout_rx_if #(.ORD(2)) gif ();
  grid_readout_rx_if #(.ORD(3)) gif3 ();

  logic       cell_valid, done, pass;
  logic [1:0] cell_row, cell_col, cell_num;
  logic [3:0] err_idx;

  logic       cell_valid3, done3, pass3;
  logic [3:0] cell_row3, cell_col3, cell_num3;
  logic [6:0] err_idx3;

  grid_readout_rx #(.ORD(2)) dut (
    .clock(clock), .reset(reset), .rq_start(rq_start), .grid(gif),
    .cell_valid(cell_valid), .cell_row(cell_row), .cell_col(cell_col), .cell_num(cell_num),
    .done(done), .pass(pass), .err_idx(err_idx)
  );

  grid_readout_rx #(.ORD(3)) dut3 (
    .clock(clock), .reset(reset), .rq_start(rq_start3), .grid(gif3),
    .cell_valid(cell_valid3), .cell_row(cell_row3), .cell_col(cell_col3), .cell_num(cell_num3),
    .done(done3), .pass(pass3), .err_idx(err_idx3)
  );

  int tests  = 0;
  int failed = 0;
  int rq_count = 0;
  logic [3:0] grid [16];

  always @(negedge clock) if (gif.rq_read === 1'b1) rq_count++;

  task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bitIndex(input logic [15:0] v);
    int n = 0;
    if ($countones(v) != 1) return 0;
    for (int k = 0; k < 16; k++) if (v[k]) n = k;
    return n;
  endfunction

  // Sudoku rules stated directly: a cell fails if it is not a single number or shares any
  // number with an earlier cell in the same row, column or 2x2 block.
  task automatic modelVerdict(output bit ok, output int first);
    ok = 1'b1;
    first = 0;
    for (int i = 0; i < 16; i++) begin
      bit bad = ($countones(grid[i]) != 1);
      for (int j = 0; j < i; j++) begin
        bit same = (i / 4 == j / 4) || (i % 4 == j % 4) ||
                   ((i / 8 == j / 8) && ((i % 4) / 2 == (j % 4) / 2));
        if (same && ((grid[i] & grid[j]) != 4'b0)) bad = 1'b1;
      end
      if (bad && ok) begin
        ok = 1'b0;
        first = i;
      end
    end
  endtask

  task automatic loadBase();
    int base [16] = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};
    for (int i = 0; i < 16; i++) grid[i] = 4'(1 << (base[i] - 1));
  endtask

  // mode 0: back-to-back, 1: alternate cycles plus a 10-cycle stall, 2: random gaps
  task automatic applyStimulus(input int mode, input bit hold_start, input int abort_after);
    bit ok, pending, stalled, go;
    int first, i, cycles, base, stall_left, er, ec, en;
    modelVerdict(ok, first);
    base = rq_count;
    pending = 0; stalled = 0; i = 0; cycles = 0; stall_left = 0;
    er = 0; ec = 0; en = 0;
    @(negedge clock);
    rq_start = 1'b1;
    @(negedge clock);
    if (!hold_start) rq_start = 1'b0;
    checkOutput("rq_read_pulse", gif.rq_read, 1);
    checkOutput("ready_in_request", gif.in_ready, 0);
    while (i < abort_after && cycles < 500) begin
      @(negedge clock);
      cycles++;
      checkOutput("cell_valid", cell_valid, pending);
      if (pending) begin
        checkOutput("cell_row", cell_row, er);
        checkOutput("cell_col", cell_col, ec);
        checkOutput("cell_num", cell_num, en);
      end
      checkOutput("done_early", done, 0);
      pending = 0;
      if (mode == 1 && i == 8 && !stalled) begin
        stall_left = 10;
        stalled = 1;
      end
      if (stall_left > 0) begin
        go = 0;
        stall_left--;
      end else if (mode == 1) go = cycles[0];
      else if (mode == 2) go = ($urandom_range(0, 3) != 0);
      else go = 1;
      gif.in_valid = go;
      gif.in_value = go ? grid[i] : 4'($urandom);
      if (go && gif.in_ready) begin
        pending = 1;
        er = i / 4; ec = i % 4; en = bitIndex(16'(grid[i]));
        i++;
        if (i == 16) rq_start = 1'b0;
      end
    end
    checkOutput("timeout", (cycles < 500) ? 1 : 0, 1);
    if (abort_after < 16) begin
      @(negedge clock);
      gif.in_valid = 1'b0;
      rq_start = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      checkOutput("rst_rq_read", gif.rq_read, 0);
      checkOutput("rst_in_ready", gif.in_ready, 0);
      checkOutput("rst_cell_valid", cell_valid, 0);
      checkOutput("rst_cell_fields", {cell_row, cell_col, cell_num}, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_pass", pass, 0);
      checkOutput("rst_err_idx", err_idx, 0);
      @(negedge clock);
      reset = 1'b0;
      return;
    end
    @(negedge clock);
    gif.in_valid = 1'b0;
    checkOutput("last_cell_valid", cell_valid, 1);
    checkOutput("last_cell_row", cell_row, er);
    checkOutput("last_cell_col", cell_col, ec);
    checkOutput("last_cell_num", cell_num, en);
    checkOutput("done", done, 1);
    checkOutput("pass", pass, ok);
    if (!ok) checkOutput("err_idx", err_idx, first);
    gif.in_valid = 1'b1;
    gif.in_value = 4'b0001;
    repeat (2) begin
      @(negedge clock);
      checkOutput("no_cell_after_done", cell_valid, 0);
      checkOutput("done_held", done, 1);
    end
    gif.in_valid = 1'b0;
    checkOutput("rq_read_count", rq_count - base, 1);
  endtask

  task automatic runSmoke3();
    int i = 0, cycles = 0, cnt = 0;
    bit pending = 0;
    int en = 0;
    @(negedge clock);
    rq_start3 = 1'b1;
    @(negedge clock);
    rq_start3 = 1'b0;
    checkOutput("ord3_rq_read", gif3.rq_read, 1);
    while (i < 81 && cycles < 300) begin
      @(negedge clock);
      cycles++;
      checkOutput("ord3_cell_valid", cell_valid3, pending);
      if (pending) begin
        checkOutput("ord3_cell_num", cell_num3, en);
        cnt++;
      end
      pending = 0;
      begin
        int r = i / 9, c = i % 9;
        int v = (3 * r + r / 3 + c) % 9;
        gif3.in_valid = 1'b1;
        gif3.in_value = 9'(1 << v);
        if (gif3.in_ready) begin
          pending = 1;
          en = v;
          i++;
        end
      end
    end
    checkOutput("ord3_timeout", (cycles < 300) ? 1 : 0, 1);
    @(negedge clock);
    gif3.in_valid = 1'b0;
    if (pending && cell_valid3) cnt++;
    checkOutput("ord3_cells", cnt, 81);
    checkOutput("ord3_done", done3, 1);
    checkOutput("ord3_pass", pass3, 1);
  endtask

  initial begin
    reset = 1'b1;
    rq_start = 1'b0;
    rq_start3 = 1'b0;
    gif.in_valid = 1'b0;
    gif.in_value = '0;
    gif3.in_valid = 1'b0;
    gif3.in_value = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_pass", pass, 0);
    checkOutput("reset_ready", gif.in_ready, 0);
    checkOutput("reset_rq_read", gif.rq_read, 0);
    checkOutput("reset_cell_valid", cell_valid, 0);
    reset = 1'b0;

    loadBase();
    applyStimulus(0, 1'b0, 16);
    loadBase();
    grid[1] = 4'b0001;
    applyStimulus(0, 1'b0, 16);
    loadBase();
    grid[6] = 4'b0000;
    grid[9] = 4'b0110;
    applyStimulus(0, 1'b0, 16);
    loadBase();
    applyStimulus(1, 1'b0, 16);
    applyStimulus(0, 1'b0, 7);
    applyStimulus(0, 1'b0, 16);
    applyStimulus(2, 1'b0, 16);
    applyStimulus(0, 1'b1, 16);

    // Random symbol relabelling and row swaps keep a grid valid; random corruptions break it.
    for (int t = 0; t < 20; t++) begin
      int perm [4] = '{0, 1, 2, 3};
      logic [3:0] tmp [16];
      for (int k = 3; k > 0; k--) begin
        int j = $urandom_range(0, k);
        int s = perm[k];
        perm[k] = perm[j];
        perm[j] = s;
      end
      loadBase();
      for (int n = 0; n < 16; n++) tmp[n] = 4'(1 << perm[bitIndex(16'(grid[n]))]);
      if ($urandom_range(0, 1) == 1)
        for (int c = 0; c < 4; c++) begin
          grid[c]     = tmp[4 + c];
          grid[4 + c] = tmp[c];
          grid[8 + c] = tmp[8 + c];
          grid[12 + c] = tmp[12 + c];
        end
      else
        for (int n = 0; n < 16; n++) grid[n] = tmp[n];
      if ($urandom_range(0, 2) != 0)
        repeat ($urandom_range(1, 2)) grid[$urandom_range(0, 15)] = 4'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 2), 1'($urandom_range(0, 1)), 16);
    end

    runSmoke3();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
